ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit of the HRM CPU, sitting between the program ROM and the control unit. It owns the program counter, drives the ROM address, and compensates for the ROM's one-cycle registered read. It assembles 1- or 2-byte instructions (opcode plus optional operand) and hands them to the control unit over a valid/ready handshake. It also accepts jump redirects and stops fetching after a HALT.

## Interface
- RESET_PC, 8'h00, program counter value after reset

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  8  ROM address (combinational, = pc_next)
- rom_data  in  8  ROM read data; equals rom[pc] one cycle after the address was presented
- instr_valid  out  1  opcode/operand/instr_pc hold a complete instruction
- instr_ready  in  1  control unit accepts the instruction this cycle
- opcode  out  8  instruction byte
- operand  out  8  operand byte; 8'h00 for 1-byte instructions
- instr_pc  out  8  address of the opcode byte
- jmp_en  in  1  redirect fetch to jmp_addr
- jmp_addr  in  8  jump target
- halted  out  1  HALT consumed; fetch stopped

## Operation
- Encoding uses the high nibble: INBOX 0x0_, OUTBOX 0x1_, COPYFROM 0x2_, COPYTO 0x3_, ADD 0x4_, SUB 0x5_, BUMPUP 0x6_, BUMPDN 0x7_, JUMP 0x8_, JUMPZ 0x9_, JUMPN 0xA_, HALT 0xF_.
- has_operand is true for high nibble 0x2 to 0xA. The low nibble passes through untouched.
- pc_next selection, in priority order:
  - rst gives RESET_PC.
  - jmp_en gives jmp_addr.
  - An advancing state gives pc+1.
  - Otherwise pc.
- rom_addr = pc_next, so rom_data always equals rom[pc] in the following cycle.
- FSM states and transitions:
  - OP: opcode<=rom_data, instr_pc<=pc, pc<=pc+1, operand<=0. Go to ARG if has_operand, else VALID.
  - ARG: operand<=rom_data, pc<=pc+1, then VALID.
  - VALID: instr_valid=1 and outputs are held stable. On instr_valid&instr_ready, go to HALTED if the opcode is HALT, else OP. pc is unchanged, and rom_data already equals the next opcode.
  - HALTED: halted=1, instr_valid=0, pc frozen.
- jmp_en in any state wins: pc<=jmp_addr, go to OP, instr_valid drops next cycle. This abandons any partially fetched or unaccepted instruction.
- jmp_en together with a handshake in VALID: the handshake counts as accepted and the jump still applies.
- jmp_en while HALTED leaves HALTED and resumes at jmp_addr.
- PC arithmetic is 8-bit modulo, so 0xFF+1 = 0x00. An operand at 0xFF is followed by a fetch at 0x00.

## Timing
- Reset values:
  - state=OP, pc=RESET_PC, opcode=0, operand=0, instr_pc=0.
  - instr_valid=0, halted=0, rom_addr=RESET_PC.
- rst mid-fetch or mid-handshake discards everything. The ROM latches rom[RESET_PC] on the reset edge, so OP is correct in the first cycle after reset.
- Latency from reset release or a jump to instr_valid:
  - 1-byte instruction: 1 cycle (OP, then VALID).
  - 2-byte instruction: 2 cycles.
- Throughput with instr_ready tied high:
  - 1-byte instructions: one instruction per 2 cycles.
  - 2-byte instructions: one instruction per 3 cycles.
- instr_valid is never withdrawn without a handshake, except by jmp_en or rst.

## Structure
- Shared package hrm_pkg holds:
  - opcode nibble constants;
  - the has_operand function;
  - the fetch state enum (OP, ARG, VALID, HALTED);
  - the 8-bit address width constant.
- No sub-module is needed. pc_next is an inline mux. The program ROM is instantiated beside this block by the CPU top.

## Test plan
- Program 0x00,0x10 with ready=1 after reset. Required:
  - opcode 0x00 at instr_pc 0x00 with operand 0x00;
  - then 0x10 at instr_pc 0x01;
  - instr_valid pulses every 2 cycles.
- Program 0x20,0x05,0x30,0x07. Required: (0x20,0x05,pc 0x00) then (0x30,0x07,pc 0x02), spaced 3 cycles apart.
- Backpressure: hold ready=0 for 5 cycles in VALID. Required:
  - outputs stable and rom_addr constant;
  - on the ready cycle the handshake occurs;
  - the next instruction is valid 1 cycle later (1-byte case).
- Jump: after handshaking 0x80,0x10, assert jmp_en with jmp_addr=0x10. Required:
  - next instruction has instr_pc 0x10;
  - a jump asserted mid-ARG drops the partial fetch.
- Wrap and halt:
  - RESET_PC=0xFE, program 0xFE:0x40, 0xFF:0x03, 0x00:0xF0. Required: (0x40,0x03,pc 0xFE), then HALT at pc 0x00.
  - After the HALT handshake, halted=1 and instr_valid stays 0 for 10+ cycles.
  - A subsequent jmp_en resumes fetching.
- Assert rst while in VALID. Required: next cycle matches the reset values, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared HRM CPU definitions: opcode nibbles, fetch states,
// address width and the operand-length decode.
package hrm_pkg;

    localparam int ADDR_W = 8;

    localparam logic [3:0] NIB_INBOX    = 4'h0;
    localparam logic [3:0] NIB_OUTBOX   = 4'h1;
    localparam logic [3:0] NIB_COPYFROM = 4'h2;
    localparam logic [3:0] NIB_COPYTO   = 4'h3;
    localparam logic [3:0] NIB_ADD      = 4'h4;
    localparam logic [3:0] NIB_SUB      = 4'h5;
    localparam logic [3:0] NIB_BUMPUP   = 4'h6;
    localparam logic [3:0] NIB_BUMPDN   = 4'h7;
    localparam logic [3:0] NIB_JUMP     = 4'h8;
    localparam logic [3:0] NIB_JUMPZ    = 4'h9;
    localparam logic [3:0] NIB_JUMPN    = 4'hA;
    localparam logic [3:0] NIB_HALT     = 4'hF;

    typedef enum logic [1:0] {
        OP,
        ARG,
        VALID,
        HALTED
    } fetch_state_e;

    function automatic logic has_operand(input logic [7:0] op);
        return (op[7:4] >= NIB_COPYFROM) && (op[7:4] <= NIB_JUMPN);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction handshake between fetch (master) and
// control unit (slave).
interface ifetch_if;
    import hrm_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        opcode;
    logic [7:0]        operand;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid,
        output opcode,
        output operand,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        input  operand,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/ifetch.sv
// HRM instruction fetch: owns the PC, hides the registered ROM
// read, assembles 1/2-byte instructions, handles jumps and HALT.
module ifetch
    import hrm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              halted,
    ifetch_if.master          fetch
);

    fetch_state_e      state;
    fetch_state_e      state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic              advance;
    logic [7:0]        opcode_q;
    logic [7:0]        operand_q;
    logic [ADDR_W-1:0] instr_pc_q;

    always_comb begin
        state_n = state;
        advance = 1'b0;
        unique case (state)
            OP: begin
                advance = 1'b1;
                state_n = has_operand(rom_data) ? ARG : VALID;
            end
            ARG: begin
                advance = 1'b1;
                state_n = VALID;
            end
            VALID: begin
                if (fetch.instr_ready) begin
                    state_n = (opcode_q[7:4] == NIB_HALT) ? HALTED : OP;
                end
            end
            HALTED: state_n = HALTED;
            default: state_n = OP;
        endcase

        pc_n = advance ? pc + 1'b1 : pc;
        if (jmp_en) begin
            pc_n    = jmp_addr;
            state_n = OP;
        end
        if (rst) begin
            pc_n    = RESET_PC;
            state_n = OP;
        end
    end

    // The ROM registers its address, so presenting pc_n now makes
    // rom_data equal rom[pc] in the next cycle.
    assign rom_addr = pc_n;

    always_ff @(posedge clk) begin
        state <= state_n;
        pc    <= pc_n;
        if (rst) begin
            opcode_q   <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
        end else if (!jmp_en) begin
            if (state == OP) begin
                opcode_q   <= rom_data;
                operand_q  <= '0;
                instr_pc_q <= pc;
            end
            if (state == ARG) begin
                operand_q <= rom_data;
            end
        end
    end

    assign fetch.instr_valid = (state == VALID);
    assign fetch.opcode      = opcode_q;
    assign fetch.operand     = operand_q;
    assign fetch.instr_pc    = instr_pc_q;
    assign halted            = (state == HALTED);

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed steps plus random programs
// checked against an instruction-level model of the fetch stream.
module tb_ifetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] rom [256];
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] rom_addr2;
    logic [7:0] rom_data2;
    logic       jmp_en   = 1'b0;
    logic [7:0] jmp_addr = 8'h00;
    logic       jmp_en2   = 1'b0;
    logic [7:0] jmp_addr2 = 8'h00;
    logic       halted;
    logic       halted2;

    int n_assert = 0;
    int n_fail   = 0;

    ifetch_if bus ();
    ifetch_if bus2 ();

    ifetch u_dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .jmp_en   (jmp_en),
        .jmp_addr (jmp_addr),
        .halted   (halted),
        .fetch    (bus)
    );

    ifetch #(.RESET_PC(8'hFE)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr2),
        .rom_data (rom_data2),
        .jmp_en   (jmp_en2),
        .jmp_addr (jmp_addr2),
        .halted   (halted2),
        .fetch    (bus2)
    );

    // Program ROM with a one-cycle registered read.
    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data2 <= rom[rom_addr2];
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit two_byte(input logic [7:0] op);
        int hi;
        hi = int'(op) / 16;
        return (hi >= 2) && (hi <= 10);
    endfunction

    task automatic wait_valid(output int c);
        c = 0;
        while (bus.instr_valid !== 1'b1 && c < 8) begin
            tick();
            c++;
        end
    endtask

    task automatic wait_valid2(output int c);
        c = 0;
        while (bus2.instr_valid !== 1'b1 && c < 8) begin
            tick();
            c++;
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.instr_ready  = 1'b0;
        bus2.instr_ready = 1'b0;
        jmp_en          = 1'b0;
        jmp_en2         = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_opcode", 32'(bus.opcode), 32'h00);
        chk("rst_operand", 32'(bus.operand), 32'h00);
        chk("rst_ipc", 32'(bus.instr_pc), 32'h00);
        chk("rst_rom_addr", 32'(rom_addr), 32'h00);
        chk("rst_rom_addr2", 32'(rom_addr2), 32'hFE);
        rst = 1'b0;
    endtask

    task automatic jump(input logic [7:0] t);
        jmp_addr = t;
        jmp_en   = 1'b1;
        tick();
        jmp_en = 1'b0;
    endtask

    // Walks the program from address a, expecting each instruction in
    // order; optional backpressure, random jumps and HALT resumption.
    task automatic run(input logic [7:0] start, input int n,
                       input int bp_max, input bit rnd_jmp);
        logic [7:0] a;
        logic [7:0] nxt;
        logic [7:0] eop;
        logic [7:0] earg;
        logic [7:0] t;
        int         len;
        int         c;
        int         hold;
        a = start;
        for (int i = 0; i < n; i++) begin
            eop  = rom[a];
            len  = two_byte(eop) ? 2 : 1;
            earg = two_byte(eop) ? rom[8'(a + 8'd1)] : 8'h00;
            nxt  = 8'(a + 8'(len));
            wait_valid(c);
            chk("latency", 32'(c), 32'(len));
            chk("opcode", 32'(bus.opcode), 32'(eop));
            chk("operand", 32'(bus.operand), 32'(earg));
            chk("instr_pc", 32'(bus.instr_pc), 32'(a));
            chk("rom_addr", 32'(rom_addr), 32'(nxt));
            chk("not_halted", 32'(halted), 32'd0);
            hold = (bp_max > 0) ? $urandom_range(bp_max, 0) : 0;
            for (int k = 0; k < hold; k++) begin
                tick();
                chk("bp_valid", 32'(bus.instr_valid), 32'd1);
                chk("bp_opcode", 32'(bus.opcode), 32'(eop));
                chk("bp_operand", 32'(bus.operand), 32'(earg));
                chk("bp_ipc", 32'(bus.instr_pc), 32'(a));
                chk("bp_rom_addr", 32'(rom_addr), 32'(nxt));
            end
            if (rnd_jmp && $urandom_range(5, 0) == 0) begin
                t = 8'($urandom);
                bus.instr_ready = 1'($urandom);
                jump(t);
                bus.instr_ready = 1'b0;
                a = t;
                continue;
            end
            bus.instr_ready = 1'b1;
            tick();
            bus.instr_ready = 1'b0;
            a = nxt;
            if (eop[7:4] == 4'hF) begin
                for (int k = 0; k < 10; k++) begin
                    chk("halt_flag", 32'(halted), 32'd1);
                    chk("halt_valid", 32'(bus.instr_valid), 32'd0);
                    chk("halt_rom_addr", 32'(rom_addr), 32'(a));
                    tick();
                end
                t = 8'($urandom);
                jump(t);
                a = t;
            end
        end
    endtask

    initial begin
        int c;
        bus.instr_ready  = 1'b0;
        bus2.instr_ready = 1'b0;
        for (int j = 0; j < 256; j++) rom[j] = 8'h00;
        tick();

        // Two 1-byte instructions back to back.
        rom[0] = 8'h00;
        rom[1] = 8'h10;
        do_reset();
        run(8'h00, 2, 0, 1'b0);

        // Two 2-byte instructions.
        rom[0] = 8'h20;
        rom[1] = 8'h05;
        rom[2] = 8'h30;
        rom[3] = 8'h07;
        do_reset();
        run(8'h00, 2, 0, 1'b0);

        // Backpressure on a 1-byte instruction.
        rom[0] = 8'h00;
        rom[1] = 8'h10;
        do_reset();
        wait_valid(c);
        chk("bp0_latency", 32'(c), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp0_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp0_opcode", 32'(bus.opcode), 32'h00);
            chk("bp0_rom_addr", 32'(rom_addr), 32'h01);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        run(8'h01, 1, 0, 1'b0);

        // Jump after a JUMP instruction, then a jump during ARG.
        rom[0]    = 8'h80;
        rom[1]    = 8'h10;
        rom[8'h10] = 8'h20;
        rom[8'h11] = 8'h33;
        rom[8'h20] = 8'h05;
        do_reset();
        run(8'h00, 1, 0, 1'b0);
        jump(8'h10);
        tick();
        chk("midarg_valid", 32'(bus.instr_valid), 32'd0);
        jump(8'h20);
        run(8'h20, 1, 0, 1'b0);

        // Jump together with a handshake in VALID.
        rom[8'h21] = 8'h11;
        rom[8'h40] = 8'h12;
        wait_valid(c);
        chk("jh_latency", 32'(c), 32'd1);
        chk("jh_ipc", 32'(bus.instr_pc), 32'h21);
        bus.instr_ready = 1'b1;
        jump(8'h40);
        bus.instr_ready = 1'b0;
        run(8'h40, 1, 0, 1'b0);

        // PC wrap and HALT on the 0xFE-reset instance.
        rom[8'hFE] = 8'h40;
        rom[8'hFF] = 8'h03;
        rom[8'h00] = 8'hF0;
        do_reset();
        wait_valid2(c);
        chk("wrap_latency", 32'(c), 32'd2);
        chk("wrap_opcode", 32'(bus2.opcode), 32'h40);
        chk("wrap_operand", 32'(bus2.operand), 32'h03);
        chk("wrap_ipc", 32'(bus2.instr_pc), 32'hFE);
        chk("wrap_rom_addr", 32'(rom_addr2), 32'h00);
        bus2.instr_ready = 1'b1;
        tick();
        bus2.instr_ready = 1'b0;
        wait_valid2(c);
        chk("halt_latency", 32'(c), 32'd1);
        chk("halt_opcode", 32'(bus2.opcode), 32'hF0);
        chk("halt_ipc", 32'(bus2.instr_pc), 32'h00);
        bus2.instr_ready = 1'b1;
        tick();
        bus2.instr_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("h2_halted", 32'(halted2), 32'd1);
            chk("h2_valid", 32'(bus2.instr_valid), 32'd0);
            tick();
        end
        jmp_addr2 = 8'hFE;
        jmp_en2   = 1'b1;
        tick();
        jmp_en2 = 1'b0;
        chk("resume_halted", 32'(halted2), 32'd0);
        wait_valid2(c);
        chk("resume_latency", 32'(c), 32'd2);
        chk("resume_ipc", 32'(bus2.instr_pc), 32'hFE);

        // Reset while an instruction is being handed over.
        rom[0] = 8'h20;
        rom[1] = 8'h44;
        rom[2] = 8'h11;
        do_reset();
        wait_valid(c);
        chk("rv_latency", 32'(c), 32'd2);
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        chk("rv_valid", 32'(bus.instr_valid), 32'd0);
        chk("rv_opcode", 32'(bus.opcode), 32'h00);
        chk("rv_operand", 32'(bus.operand), 32'h00);
        chk("rv_ipc", 32'(bus.instr_pc), 32'h00);
        chk("rv_rom_addr", 32'(rom_addr), 32'h00);
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        run(8'h00, 2, 0, 1'b0);

        // Random programs with random backpressure and jumps.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 256; j++) rom[j] = 8'($urandom);
            do_reset();
            run(8'h00, 25, 3, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
